// File: rtl/demux_pkg.sv
// demux_pkg: shared types for the 8-bit demux router
package demux_pkg;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {LANE_EMPTY, LANE_PARTIAL, LANE_FULL} lane_state_e;
   typedef logic [DATA_W-1:0] byte_t;
endpackage

// File: rtl/demux_lane_fifo.sv
// demux_lane_fifo: one output lane's byte buffer with its routed-byte counter
module demux_lane_fifo
   import demux_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  byte_t            din,
   input  logic             pop,
   output byte_t            dout,
   output logic             valid,
   output logic             full,
   output logic [CNT_W-1:0] route_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   byte_t       mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   lane_state_e state;
   always_comb begin
      state = count == '0 ? LANE_EMPTY : count == CW'(DEPTH) ? LANE_FULL : LANE_PARTIAL;
      valid = state != LANE_EMPTY;
      full  = state == LANE_FULL;
      dout  = mem[rd_ptr];
   end
   // push and pop arrive already qualified by full/valid from the router
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         route_cnt <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
            route_cnt   <= route_cnt + CNT_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/eight_bit_demux_router.sv
// eight_bit_demux_router: steers one byte stream into two independently buffered lanes
module eight_bit_demux_router
   import demux_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  byte_t            In_Data,
   input  logic             In_SEL,
   input  logic             In_Valid,
   output logic             In_Ready,
   output byte_t            DEMUX_Out_0,
   output logic             Out_Valid_0,
   input  logic             Out_Ready_0,
   output byte_t            DEMUX_Out_1,
   output logic             Out_Valid_1,
   input  logic             Out_Ready_1,
   output logic [CNT_W-1:0] Route_Cnt_0,
   output logic [CNT_W-1:0] Route_Cnt_1
);
   logic full_0, full_1, push, push_0, push_1, pop_0, pop_1;
   // ready depends only on the selected lane's registered fullness, never on consumers
   always_comb begin
      In_Ready = In_SEL ? ~full_1 : ~full_0;
      push     = In_Valid & In_Ready;
      push_0   = push & ~In_SEL;
      push_1   = push & In_SEL;
      pop_0    = Out_Valid_0 & Out_Ready_0;
      pop_1    = Out_Valid_1 & Out_Ready_1;
   end
   demux_lane_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_0 (
      .clk       (clk),
      .reset     (reset),
      .push      (push_0),
      .din       (In_Data),
      .pop       (pop_0),
      .dout      (DEMUX_Out_0),
      .valid     (Out_Valid_0),
      .full      (full_0),
      .route_cnt (Route_Cnt_0)
   );
   demux_lane_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_1 (
      .clk       (clk),
      .reset     (reset),
      .push      (push_1),
      .din       (In_Data),
      .pop       (pop_1),
      .dout      (DEMUX_Out_1),
      .valid     (Out_Valid_1),
      .full      (full_1),
      .route_cnt (Route_Cnt_1)
   );
endmodule
